// File: rtl/aer_spike_injector_pkg.sv
// Shared types for the AER spike injector.
//   aer_evt_t   : one queued synapse event (polarity + synapse index)
//   inj_state_t : injector step FSM state
package snn_pkg;
  localparam int NUM_SYN_DEF = 8;
  localparam int ADDR_W_DEF  = $clog2(NUM_SYN_DEF);

  typedef struct packed {
    logic                  inh;
    logic [ADDR_W_DEF-1:0] addr;
  } aer_evt_t;

  typedef enum logic [1:0] {IDLE, DRAIN, EMIT} inj_state_t;
endpackage

// File: rtl/aer_spike_injector_if.sv
// AER event stream between a spike source (master) and the injector (slave).
//   i_evt_valid : event present
//   i_evt_inh   : 1 = inhibitory, 0 = excitatory
//   i_evt_addr  : synapse index
//   o_evt_ready : injector can take the event this cycle
interface aer_spike_injector_if #(
  parameter int ADDR_W = 3
) ();
  logic              i_evt_valid;
  logic              i_evt_inh;
  logic [ADDR_W-1:0] i_evt_addr;
  logic              o_evt_ready;

  modport master (output i_evt_valid, i_evt_inh, i_evt_addr, input o_evt_ready);
  modport slave  (input i_evt_valid, i_evt_inh, i_evt_addr, output o_evt_ready);
endinterface

// File: rtl/aer_spike_injector_fifo.sv
// spike_evt_fifo: synchronous FIFO of aer_evt_t.
//   push/push_data : write one entry (caller keeps push low when full)
//   pop/pop_data   : pop_data shows the head; pop advances (caller keeps it low when empty)
//   full/empty/count : occupancy, all from registers
module spike_evt_fifo
  import snn_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  aer_evt_t push_data,
  input  logic     pop,
  output aer_evt_t pop_data,
  output logic     full,
  output logic     empty,
  output logic [PW:0] count
);
  aer_evt_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
endmodule

// File: rtl/aer_spike_injector.sv
// aer_spike_injector: buffers AER synapse events and folds them into per-timestep
// excitatory/inhibitory spike vectors, emitted for one cycle per accepted tick.
//   clk, reset (async, active low)
//   evt            : AER event stream (slave side)
//   i_tick         : timestep boundary strobe
//   o_excitatory / o_inhibitory : spike vectors, valid only while o_step_valid
//   o_step_valid   : one-cycle step strobe
//   o_overrun      : one-cycle pulse after a tick arriving in DRAIN/EMIT was dropped
//   o_collide_cnt / o_overrun_cnt : saturating statistics, only with AER_INJ_STATS_EN
// All outputs come straight from flops.
module aer_spike_injector
  import snn_pkg::*;
#(
  parameter int NUM_SYN    = NUM_SYN_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
`ifdef AER_INJ_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  aer_spike_injector_if.slave evt,
  input  logic               i_tick,
  output logic [NUM_SYN-1:0] o_excitatory,
  output logic [NUM_SYN-1:0] o_inhibitory,
  output logic               o_step_valid,
  output logic               o_overrun
`ifdef AER_INJ_STATS_EN
  , output logic [CNT_W-1:0] o_collide_cnt
  , output logic [CNT_W-1:0] o_overrun_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  inj_state_t         state_q, state_d;
  logic [NUM_SYN-1:0] acc_e_q, acc_e_d, acc_i_q, acc_i_d;
  logic [NUM_SYN-1:0] exc_q, exc_d, inh_q, inh_d;
  logic [CW-1:0]      drain_q, drain_d;
  logic               ready_q, ready_d, sv_q, sv_d, ovr_q, ovr_d;

  logic               push, pop, collide, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count, occ_next;
  aer_evt_t           push_evt, pop_evt;

  assign push_evt = '{inh: evt.i_evt_inh, addr: evt.i_evt_addr};
  assign push     = evt.i_evt_valid && ready_q && !fifo_full;
  assign pop      = (state_q != EMIT) && !fifo_empty;
  // Occupancy after this cycle's push/pop: the number of events owned by a tick now.
  assign occ_next = fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  spike_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (pop_evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    acc_e_d = acc_e_q;
    acc_i_d = acc_i_q;
    drain_d = drain_q;
    collide = 1'b0;

    // Out-of-range addresses are popped and dropped.
    if (pop && (int'(pop_evt.addr) < NUM_SYN)) begin
      if (pop_evt.inh) begin
        collide = acc_i_q[pop_evt.addr];
        acc_i_d[pop_evt.addr] = 1'b1;
      end else begin
        collide = acc_e_q[pop_evt.addr];
        acc_e_d[pop_evt.addr] = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (i_tick) begin
        if (occ_next != '0) begin
          state_d = DRAIN;
          drain_d = occ_next;
        end else begin
          state_d = EMIT;
        end
      end
      // Entries counted at the tick are guaranteed present, so pop fires every cycle.
      DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == CW'(1)) state_d = EMIT;
      end
      EMIT: begin
        acc_e_d = '0;
        acc_i_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Load the step outputs on entry to EMIT, including this cycle's final pop.
    sv_d    = (state_d == EMIT);
    exc_d   = sv_d ? acc_e_d : '0;
    inh_d   = sv_d ? acc_i_d : '0;
    ovr_d   = i_tick && (state_q != IDLE);
    ready_d = (occ_next != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_e_q <= '0;
      acc_i_q <= '0;
      drain_q <= '0;
      exc_q   <= '0;
      inh_q   <= '0;
      sv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_e_q <= acc_e_d;
      acc_i_q <= acc_i_d;
      drain_q <= drain_d;
      exc_q   <= exc_d;
      inh_q   <= inh_d;
      sv_q    <= sv_d;
      ovr_q   <= ovr_d;
      ready_q <= ready_d;
    end
  end

  assign evt.o_evt_ready = ready_q;
  assign o_excitatory    = exc_q;
  assign o_inhibitory    = inh_q;
  assign o_step_valid    = sv_q;
  assign o_overrun       = ovr_q;

`ifdef AER_INJ_STATS_EN
  logic [CNT_W-1:0] ccnt_q, ccnt_d, ocnt_q, ocnt_d;

  always_comb begin
    ccnt_d = (collide && ccnt_q != '1) ? ccnt_q + 1'b1 : ccnt_q;
    ocnt_d = (ovr_d   && ocnt_q != '1) ? ocnt_q + 1'b1 : ocnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ccnt_q <= '0;
      ocnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_d;
      ocnt_q <= ocnt_d;
    end
  end

  assign o_collide_cnt = ccnt_q;
  assign o_overrun_cnt = ocnt_q;
`else
  logic unused_collide;
  assign unused_collide = collide;
`endif
endmodule

// File: tb/tb_aer_spike_injector.sv
module tb_aer_spike_injector;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] exc, inh;
  logic       sv, ovr;
`ifdef AER_INJ_STATS_EN
  logic [15:0] ccnt, ocnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aer_spike_injector_if #(.ADDR_W(3)) evt_if ();

  aer_spike_injector dut (
    .clk           (clk),
    .reset         (reset),
    .evt           (evt_if),
    .i_tick        (tick),
    .o_excitatory  (exc),
    .o_inhibitory  (inh),
    .o_step_valid  (sv),
    .o_overrun     (ovr)
`ifdef AER_INJ_STATS_EN
    , .o_collide_cnt (ccnt)
    , .o_overrun_cnt (ocnt)
`endif
  );

  // One row per clock cycle: inputs driven in that cycle, outputs expected in that cycle.
  typedef struct {
    logic       v;
    logic       ih;
    logic [2:0] addr;
    logic       tk;
    logic       rdy;
    logic [7:0] e_exc;
    logic [7:0] e_inh;
    logic       e_sv;
    logic       e_ovr;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(logic v, logic ih, logic [2:0] a, logic tk,
                              logic rdy, logic [7:0] ee, logic [7:0] ei, logic es, logic eo);
    vec_t r;
    r.v = v; r.ih = ih; r.addr = a; r.tk = tk;
    r.rdy = rdy; r.e_exc = ee; r.e_inh = ei; r.e_sv = es; r.e_ovr = eo;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ih, input logic [2:0] a, input logic tk);
    evt_if.i_evt_valid = v;
    evt_if.i_evt_inh   = ih;
    evt_if.i_evt_addr  = a;
    tick               = tk;
  endtask

  task automatic chk_outs(input string nm, input logic rdy, input logic [7:0] ee,
                          input logic [7:0] ei, input logic es, input logic eo);
    chk({nm, ".ready"}, {31'd0, evt_if.o_evt_ready}, {31'd0, rdy});
    chk({nm, ".exc"},   {24'd0, exc}, {24'd0, ee});
    chk({nm, ".inh"},   {24'd0, inh}, {24'd0, ei});
    chk({nm, ".sv"},    {31'd0, sv},  {31'd0, es});
    chk({nm, ".ovr"},   {31'd0, ovr}, {31'd0, eo});
  endtask

  initial begin
    //            v ih a tk  | rdy exc    inh    sv ovr
    // empty tick -> zero step next cycle
    tbl[0]  = mk(0,0,0,1, 1,8'h00,8'h00,0,0);
    tbl[1]  = mk(0,0,0,0, 1,8'h00,8'h00,1,0);
    // exc3, inh5, then tick once drained
    tbl[2]  = mk(1,0,3,0, 1,8'h00,8'h00,0,0);
    tbl[3]  = mk(1,1,5,0, 1,8'h00,8'h00,0,0);
    tbl[4]  = mk(0,0,0,0, 1,8'h00,8'h00,0,0);
    tbl[5]  = mk(0,0,0,1, 1,8'h00,8'h00,0,0);
    tbl[6]  = mk(0,0,0,0, 1,8'h08,8'h20,1,0);
    // exc0 twice in one step -> single bit, one collision
    tbl[7]  = mk(1,0,0,0, 1,8'h00,8'h00,0,0);
    tbl[8]  = mk(1,0,0,0, 1,8'h00,8'h00,0,0);
    tbl[9]  = mk(0,0,0,0, 1,8'h00,8'h00,0,0);
    tbl[10] = mk(0,0,0,1, 1,8'h00,8'h00,0,0);
    tbl[11] = mk(0,0,0,0, 1,8'h01,8'h00,1,0);
    // continuous pushes: tick with N=1, second tick on the last DRAIN pop (ignored)
    tbl[12] = mk(1,0,1,0, 1,8'h00,8'h00,0,0);
    tbl[13] = mk(1,0,2,1, 1,8'h00,8'h00,0,0);
    tbl[14] = mk(1,0,4,1, 1,8'h00,8'h00,0,0);
    tbl[15] = mk(1,0,5,0, 1,8'h06,8'h00,1,1);
    // exc4/exc5 (pushed during DRAIN/EMIT) belong to this step, N=2
    tbl[16] = mk(1,1,0,1, 1,8'h00,8'h00,0,0);
    tbl[17] = mk(1,1,1,0, 1,8'h00,8'h00,0,0);
    tbl[18] = mk(1,1,2,0, 1,8'h00,8'h00,0,0);
    tbl[19] = mk(1,1,3,0, 1,8'h30,8'h01,1,0);
    // tick with 3 queued at T=20, second tick in DRAIN, EMIT at T+4
    tbl[20] = mk(1,1,4,1, 1,8'h00,8'h00,0,0);
    tbl[21] = mk(1,0,6,1, 1,8'h00,8'h00,0,0);
    tbl[22] = mk(1,0,7,0, 1,8'h00,8'h00,0,1);
    tbl[23] = mk(1,0,0,0, 1,8'h00,8'h00,0,0);
    // push during EMIT fills FIFO to 4 -> ready low; held event accepted a cycle later
    tbl[24] = mk(1,0,3,0, 1,8'h00,8'h1E,1,0);
    tbl[25] = mk(1,0,1,0, 0,8'h00,8'h00,0,0);
    tbl[26] = mk(1,0,1,1, 1,8'h00,8'h00,0,0);
    tbl[27] = mk(0,0,0,0, 1,8'h00,8'h00,0,0);
    tbl[28] = mk(0,0,0,0, 1,8'h00,8'h00,0,0);
    tbl[29] = mk(0,0,0,0, 1,8'h00,8'h00,0,0);
    // tick during EMIT -> overrun next cycle
    tbl[30] = mk(0,0,0,1, 1,8'hCB,8'h00,1,0);
    tbl[31] = mk(0,0,0,0, 1,8'h00,8'h00,0,1);

    drive(0, 0, 3'd0, 0);
    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 8'h00, 8'h00, 0, 0);
    reset = 1'b1;
    #1 chk({"rel.ready"}, {31'd0, evt_if.o_evt_ready}, 32'd0);
    @(posedge clk);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk_outs($sformatf("row%0d", i), tbl[i].rdy, tbl[i].e_exc, tbl[i].e_inh,
               tbl[i].e_sv, tbl[i].e_ovr);
      drive(tbl[i].v, tbl[i].ih, tbl[i].addr, tbl[i].tk);
    end

    @(negedge clk);
    chk_outs("post", 1, 8'h00, 8'h00, 0, 0);
`ifdef AER_INJ_STATS_EN
    chk("collide_cnt", {16'd0, ccnt}, 32'd1);
    chk("overrun_cnt", {16'd0, ocnt}, 32'd3);
`endif

    // Reset in the middle of a DRAIN discards the pending event.
    drive(1, 0, 3'd2, 1);
    @(negedge clk);
    drive(0, 0, 3'd0, 0);
    chk_outs("drain", 1, 8'h00, 8'h00, 0, 0);
    reset = 1'b0;
    #1 chk_outs("rst_mid", 0, 8'h00, 8'h00, 0, 0);
`ifdef AER_INJ_STATS_EN
    chk("rst_ccnt", {16'd0, ccnt}, 32'd0);
    chk("rst_ocnt", {16'd0, ocnt}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_outs("rst_rel", 1, 8'h00, 8'h00, 0, 0);
    drive(0, 0, 3'd0, 1);
    @(negedge clk);
    drive(0, 0, 3'd0, 0);
    chk_outs("rst_step", 1, 8'h00, 8'h00, 1, 0);
    @(negedge clk);
    chk_outs("rst_idle", 1, 8'h00, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
